// File: rtl/msix_message_scheduler.sv
// msix_message_scheduler: latches MSI-X events into the PBA, picks a vector round-robin, fetches its table entry and issues one memory write
module msix_message_scheduler #(
    parameter int NUM_VECTORS = 8,
    parameter int IDX_W       = $clog2(NUM_VECTORS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   msix_enable,
    input  logic                   func_mask,
    input  logic [NUM_VECTORS-1:0] vec_mask,
    input  logic [NUM_VECTORS-1:0] irq_req,
    output logic [NUM_VECTORS-1:0] pending,
    output logic                   tbl_rd_req,
    output logic [IDX_W-1:0]       tbl_rd_idx,
    input  logic                   tbl_rd_valid,
    input  logic [63:0]            tbl_addr,
    input  logic [31:0]            tbl_data,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [63:0]            msg_addr,
    output logic [31:0]            msg_data,
    output logic [IDX_W-1:0]       msg_vec,
    output logic                   err_misaligned
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t                 state_q, state_d;
    logic [NUM_VECTORS-1:0] pending_q, pending_d, elig, clr;
    logic [IDX_W-1:0]       ptr_q, ptr_d, vec_q, vec_d, pick, cand;
    logic [63:0]            addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   tbl_rd_req_q, tbl_rd_req_d, msg_valid_q, msg_valid_d, err_q, err_d;
    logic                   found, cap, misal, hs;

    assign elig  = pending_q & ~vec_mask & {NUM_VECTORS{msix_enable & ~func_mask}};
    assign cap   = (state_q == FETCH) && tbl_rd_valid;
    assign misal = tbl_addr[1:0] != 2'b00;
    assign hs    = (state_q == SEND) && msg_ready;
    assign clr   = {NUM_VECTORS{hs | (cap & misal)}} & (NUM_VECTORS'(1) << vec_q);

    // Round-robin search: first eligible vector at or after the pointer, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_VECTORS);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // All state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            ptr_q        <= '0;
            vec_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            tbl_rd_req_q <= 1'b0;
            msg_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ptr_q        <= ptr_d;
            vec_q        <= vec_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            tbl_rd_req_q <= tbl_rd_req_d;
            msg_valid_q  <= msg_valid_d;
            err_q        <= err_d;
        end
    end

    // Next state: a fetch whose vector lost eligibility returns to IDLE without sending
    always_comb begin
        state_d = (state_q == IDLE)  ? (found ? FETCH : IDLE)
                : (state_q == FETCH) ? (!tbl_rd_valid ? FETCH : (!misal && elig[vec_q]) ? SEND : IDLE)
                : (state_q == SEND)  ? (msg_ready ? IDLE : SEND)
                : IDLE;
    end

    // Output and datapath next values; set of pending wins over the clear
    always_comb begin
        tbl_rd_req_d = (state_q == IDLE) && found;
        vec_d        = tbl_rd_req_d ? pick : vec_q;
        ptr_d        = tbl_rd_req_d ? ((pick == IDX_W'(NUM_VECTORS - 1)) ? '0 : pick + 1'b1) : ptr_q;
        addr_d       = cap ? tbl_addr : addr_q;
        data_d       = cap ? tbl_data : data_q;
        msg_valid_d  = state_d == SEND;
        err_d        = cap && misal;
        pending_d    = (pending_q & ~clr) | irq_req;
    end

    assign pending        = pending_q;
    assign tbl_rd_req     = tbl_rd_req_q;
    assign tbl_rd_idx     = vec_q;
    assign msg_valid      = msg_valid_q;
    assign msg_addr       = addr_q;
    assign msg_data       = data_q;
    assign msg_vec        = vec_q;
    assign err_misaligned = err_q;
endmodule
